// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode
//   Pipeline decode stage for a 16-bit LC-3 style datapath. Captures the
//   fetched instruction and its npc, and produces registered execute,
//   writeback and memory controls one cycle later.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous active-high reset
//   enable_decode in   capture strobe
//   dout[15:0]    in   fetched instruction word
//   npc_in[15:0]  in   pc+1 paired with dout
//   br_taken      in   flush: instruction in decode is on the wrong path
//   IR[15:0]      out  registered instruction
//   npc_out[15:0] out  registered npc
//   E_Control[5:0]out  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_Control[1:0]out  writeback source (00 ALU, 01 memory, 10 PC-relative)
//   Mem_Control   out  indirect memory access (LDI/STI)
//   reg_wr        out  destination register write enable
//   valid_out     out  outputs hold a live instruction
//   illegal_op    out  registered opcode is unsupported
//   decode_count  out  instructions accepted since reset (wraps at 2^16)
// -----------------------------------------------------------------------------
module decode (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    input  logic        br_taken,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control,
    output logic        reg_wr,
    output logic        valid_out,
    output logic        illegal_op,
    output logic [15:0] decode_count
);

    typedef enum logic [3:0] {
        OP_BR  = 4'b0000,
        OP_ADD = 4'b0001,
        OP_LD  = 4'b0010,
        OP_ST  = 4'b0011,
        OP_AND = 4'b0101,
        OP_LDR = 4'b0110,
        OP_STR = 4'b0111,
        OP_NOT = 4'b1001,
        OP_LDI = 4'b1010,
        OP_STI = 4'b1011,
        OP_JMP = 4'b1100,
        OP_LEA = 4'b1110
    } opcode_t;

    opcode_t     w_op;
    logic        w_op2sel;
    logic [5:0]  w_e_ctl;
    logic [1:0]  w_w_ctl;
    logic        w_mem;
    logic        w_reg_wr;
    logic        w_illegal;

    logic [15:0] r_ir;
    logic [15:0] r_npc;
    logic [5:0]  r_e_ctl;
    logic [1:0]  r_w_ctl;
    logic        r_mem;
    logic        r_reg_wr;
    logic        r_valid;
    logic        r_illegal;
    logic [15:0] r_count;

    assign w_op     = opcode_t'(dout[15:12]);
    // bit 5 selects immediate form; op2select=1 picks the register operand
    assign w_op2sel = ~dout[5];

    always_comb begin
        w_e_ctl   = '0;
        w_w_ctl   = '0;
        w_mem     = 1'b0;
        w_reg_wr  = 1'b0;
        w_illegal = 1'b0;
        case (w_op)
            OP_ADD: begin w_e_ctl = {5'b00000, w_op2sel}; w_reg_wr = 1'b1; end
            OP_AND: begin w_e_ctl = {5'b01000, w_op2sel}; w_reg_wr = 1'b1; end
            OP_NOT: begin w_e_ctl = 6'b100000;            w_reg_wr = 1'b1; end
            OP_BR:  begin w_e_ctl = 6'b000110; end
            OP_JMP: begin w_e_ctl = 6'b001100; end
            OP_LD:  begin w_e_ctl = 6'b000110; w_w_ctl = 2'b01; w_reg_wr = 1'b1; end
            OP_LDI: begin w_e_ctl = 6'b000110; w_w_ctl = 2'b01; w_reg_wr = 1'b1; w_mem = 1'b1; end
            OP_LDR: begin w_e_ctl = 6'b001000; w_w_ctl = 2'b01; w_reg_wr = 1'b1; end
            OP_ST:  begin w_e_ctl = 6'b000110; end
            OP_STI: begin w_e_ctl = 6'b000110; w_mem = 1'b1; end
            OP_STR: begin w_e_ctl = 6'b001000; end
            OP_LEA: begin w_e_ctl = 6'b000110; w_w_ctl = 2'b10; w_reg_wr = 1'b1; end
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir      <= '0;
            r_npc     <= '0;
            r_e_ctl   <= '0;
            r_w_ctl   <= '0;
            r_mem     <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else if (br_taken) begin
            // flush kills side-effecting controls; IR/npc and path selects hold
            r_mem     <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (enable_decode) begin
            r_ir      <= dout;
            r_npc     <= npc_in;
            r_e_ctl   <= w_e_ctl;
            r_w_ctl   <= w_w_ctl;
            r_mem     <= w_mem;
            r_reg_wr  <= w_reg_wr;
            r_valid   <= 1'b1;
            r_illegal <= w_illegal;
            r_count   <= r_count + 16'd1;
        end
    end

    assign IR           = r_ir;
    assign npc_out      = r_npc;
    assign E_Control    = r_e_ctl;
    assign W_Control    = r_w_ctl;
    assign Mem_Control  = r_mem;
    assign reg_wr       = r_reg_wr;
    assign valid_out    = r_valid;
    assign illegal_op   = r_illegal;
    assign decode_count = r_count;

endmodule

// File: tb/tb_decode.sv
// -----------------------------------------------------------------------------
// tb_decode
//   Self-checking bench for decode: a table-driven reference model tracks the
//   expected outputs every cycle, plus directed cases with literal values.
// -----------------------------------------------------------------------------
module tb_decode;

    logic        clock;
    logic        reset;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic        br_taken;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        reg_wr;
    logic        valid_out;
    logic        illegal_op;
    logic [15:0] decode_count;

    decode dut (
        .clock        (clock),
        .reset        (reset),
        .enable_decode(enable_decode),
        .dout         (dout),
        .npc_in       (npc_in),
        .br_taken     (br_taken),
        .IR           (IR),
        .npc_out      (npc_out),
        .E_Control    (E_Control),
        .W_Control    (W_Control),
        .Mem_Control  (Mem_Control),
        .reg_wr       (reg_wr),
        .valid_out    (valid_out),
        .illegal_op   (illegal_op),
        .decode_count (decode_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Per-opcode control tables, filled from the instruction set description.
    logic [5:0] t_e   [16];
    logic [1:0] t_w   [16];
    logic       t_rw  [16];
    logic       t_mem [16];
    logic       t_ill [16];
    logic       t_alu [16];   // ALU ops whose op2select comes from bit 5

    initial begin
        for (int i = 0; i < 16; i++) begin
            t_e[i] = 6'd0; t_w[i] = 2'd0; t_rw[i] = 1'b0;
            t_mem[i] = 1'b0; t_ill[i] = 1'b1; t_alu[i] = 1'b0;
        end
        // ADD, AND, NOT
        t_e[1]  = 6'b000000; t_rw[1]  = 1'b1; t_ill[1]  = 1'b0; t_alu[1] = 1'b1;
        t_e[5]  = 6'b010000; t_rw[5]  = 1'b1; t_ill[5]  = 1'b0; t_alu[5] = 1'b1;
        t_e[9]  = 6'b100000; t_rw[9]  = 1'b1; t_ill[9]  = 1'b0;
        // BR, JMP
        t_e[0]  = 6'b000110; t_ill[0]  = 1'b0;
        t_e[12] = 6'b001100; t_ill[12] = 1'b0;
        // LD, LDI, LDR
        t_e[2]  = 6'b000110; t_w[2]  = 2'b01; t_rw[2]  = 1'b1; t_ill[2]  = 1'b0;
        t_e[10] = 6'b000110; t_w[10] = 2'b01; t_rw[10] = 1'b1; t_ill[10] = 1'b0; t_mem[10] = 1'b1;
        t_e[6]  = 6'b001000; t_w[6]  = 2'b01; t_rw[6]  = 1'b1; t_ill[6]  = 1'b0;
        // ST, STI, STR
        t_e[3]  = 6'b000110; t_ill[3]  = 1'b0;
        t_e[11] = 6'b000110; t_ill[11] = 1'b0; t_mem[11] = 1'b1;
        t_e[7]  = 6'b001000; t_ill[7]  = 1'b0;
        // LEA
        t_e[14] = 6'b000110; t_w[14] = 2'b10; t_rw[14] = 1'b1; t_ill[14] = 1'b0;
    end

    // Reference model state
    bit          m_known = 1'b0;
    logic [15:0] m_ir, m_npc;
    logic [5:0]  m_e;
    logic [1:0]  m_w;
    logic        m_mem, m_rw, m_valid, m_ill;
    int          m_count;

    always @(posedge clock) begin
        if (reset) begin
            m_known = 1'b1;
            m_ir = 16'h0; m_npc = 16'h0; m_e = 6'h0; m_w = 2'h0;
            m_mem = 1'b0; m_rw = 1'b0; m_valid = 1'b0; m_ill = 1'b0;
            m_count = 0;
        end else if (br_taken) begin
            m_mem = 1'b0; m_rw = 1'b0; m_valid = 1'b0; m_ill = 1'b0;
        end else if (enable_decode) begin
            int op;
            op      = int'(dout >> 12);
            m_ir    = dout;
            m_npc   = npc_in;
            m_e     = t_e[op] + ((t_alu[op] && dout[5] == 1'b0) ? 6'd1 : 6'd0);
            m_w     = t_w[op];
            m_rw    = t_rw[op];
            m_mem   = t_mem[op];
            m_ill   = t_ill[op];
            m_valid = 1'b1;
            m_count = (m_count + 1) % 65536;
        end
    end

    always @(negedge clock) begin
        if (m_known) begin
            chk("m_IR",           IR,                   m_ir);
            chk("m_npc_out",      npc_out,              m_npc);
            chk("m_E_Control",    {10'd0, E_Control},   {10'd0, m_e});
            chk("m_W_Control",    {14'd0, W_Control},   {14'd0, m_w});
            chk("m_Mem_Control",  {15'd0, Mem_Control}, {15'd0, m_mem});
            chk("m_reg_wr",       {15'd0, reg_wr},      {15'd0, m_rw});
            chk("m_valid_out",    {15'd0, valid_out},   {15'd0, m_valid});
            chk("m_illegal_op",   {15'd0, illegal_op},  {15'd0, m_ill});
            chk("m_decode_count", decode_count,         16'(m_count));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_IR"},    IR,                   16'h0000);
        chk({tag, "_npc"},   npc_out,              16'h0000);
        chk({tag, "_E"},     {10'd0, E_Control},   16'h0000);
        chk({tag, "_W"},     {14'd0, W_Control},   16'h0000);
        chk({tag, "_mem"},   {15'd0, Mem_Control}, 16'h0000);
        chk({tag, "_rw"},    {15'd0, reg_wr},      16'h0000);
        chk({tag, "_valid"}, {15'd0, valid_out},   16'h0000);
        chk({tag, "_ill"},   {15'd0, illegal_op},  16'h0000);
        chk({tag, "_cnt"},   decode_count,         16'h0000);
    endtask

    initial begin
        reset = 1'b1; enable_decode = 1'b0; br_taken = 1'b0;
        dout = 16'h0000; npc_in = 16'h0000;
        tick(); tick();
        chk_reset_vals("rst0");

        // ADD register form
        reset = 1'b0; enable_decode = 1'b1; dout = 16'h1042; npc_in = 16'h3001;
        tick();
        chk("add_IR",    IR,                  16'h1042);
        chk("add_npc",   npc_out,             16'h3001);
        chk("add_E",     {10'd0, E_Control},  16'h0001);
        chk("add_W",     {14'd0, W_Control},  16'h0000);
        chk("add_rw",    {15'd0, reg_wr},     16'h0001);
        chk("add_valid", {15'd0, valid_out},  16'h0001);
        chk("add_cnt",   decode_count,        16'h0001);

        // LDI then STR back-to-back
        dout = 16'hA403; npc_in = 16'h3002;
        tick();
        chk("ldi_mem", {15'd0, Mem_Control}, 16'h0001);
        chk("ldi_W",   {14'd0, W_Control},   16'h0001);
        dout = 16'h7A82; npc_in = 16'h3003;
        tick();
        chk("str_mem", {15'd0, Mem_Control}, 16'h0000);
        chk("str_E",   {10'd0, E_Control},   16'h0008);
        chk("str_rw",  {15'd0, reg_wr},      16'h0000);
        chk("str_cnt", decode_count,         16'h0003);

        // Stall for three cycles while dout changes
        enable_decode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dout = 16'(16'h1111 * (i + 1)); npc_in = 16'(16'h0100 + i);
            tick();
            chk("stall_IR",  IR,                  16'h7A82);
            chk("stall_npc", npc_out,             16'h3003);
            chk("stall_E",   {10'd0, E_Control},  16'h0008);
            chk("stall_cnt", decode_count,        16'h0003);
        end

        // Flush beats capture
        enable_decode = 1'b1; br_taken = 1'b1; dout = 16'h5020; npc_in = 16'h4000;
        tick();
        chk("flush_valid", {15'd0, valid_out}, 16'h0000);
        chk("flush_rw",    {15'd0, reg_wr},    16'h0000);
        chk("flush_IR",    IR,                 16'h7A82);
        chk("flush_cnt",   decode_count,       16'h0003);

        // Illegal opcode
        br_taken = 1'b0; dout = 16'hD000; npc_in = 16'h4001;
        tick();
        chk("ill_flag",  {15'd0, illegal_op}, 16'h0001);
        chk("ill_E",     {10'd0, E_Control},  16'h0000);
        chk("ill_rw",    {15'd0, reg_wr},     16'h0000);
        chk("ill_valid", {15'd0, valid_out},  16'h0001);
        chk("ill_cnt",   decode_count,        16'h0004);

        // Randomized traffic, including resets mid-stall and mid-flush
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(63) == 0);
            br_taken      = ($urandom_range(4) == 0);
            enable_decode = ($urandom_range(3) != 0);
            dout          = 16'($urandom);
            npc_in        = 16'($urandom);
            tick();
        end

        // Counter wrap: reset, then exactly 65536 captures
        reset = 1'b1; br_taken = 1'b0; enable_decode = 1'b0;
        tick();
        reset = 1'b0; enable_decode = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            dout   = 16'($urandom);
            npc_in = 16'($urandom);
            tick();
            if (i == 0) chk("first_cnt", decode_count, 16'h0001);
        end
        chk("wrap_cnt",   decode_count,       16'h0000);
        chk("wrap_valid", {15'd0, valid_out}, 16'h0001);

        // Reset mid-stream with capture and flush both requested
        reset = 1'b1; br_taken = 1'b1; dout = 16'h1234; npc_in = 16'h5678;
        tick();
        chk_reset_vals("rst1");
        reset = 1'b0; br_taken = 1'b0; enable_decode = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed at 16-bit instructions and addresses.
REQ-002 The module SHALL have port: clock  input  1  single clock, all state updates on its rising edge.
REQ-003 The module SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 The module SHALL have port: enable_decode  input  1  capture strobe from pipeline controller.
REQ-005 The module SHALL have port: dout  input  16  instruction word returned by instruction memory for the current fetch.
REQ-006 The module SHALL have port: npc_in  input  16  fetch-stage npc (pc+1) paired with dout.
REQ-007 The module SHALL have port: br_taken  input  1  flush request; the instruction in decode is on the wrong path.
REQ-008 The module SHALL have port: IR  output  16  registered instruction.
REQ-009 The module SHALL have port: npc_out  output  16  registered npc.
REQ-010 The module SHALL have port: E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
REQ-011 The module SHALL have port: W_Control  output  2  writeback source (00 ALU, 01 memory, 10 PC-relative address).
REQ-012 The module SHALL have port: Mem_Control  output  1  1 = indirect memory access (LDI/STI).
REQ-013 The module SHALL have port: reg_wr  output  1  destination-register write enable.
REQ-014 The module SHALL have port: valid_out  output  1  registered outputs hold a live instruction.
REQ-015 The module SHALL have port: illegal_op  output  1  registered opcode is unsupported.
REQ-016 The module SHALL have port: decode_count  output  16  number of instructions accepted since reset.

Function
REQ-017 The module SHALL register all outputs; capture occurs on the rising clock edge when enable_decode=1 and br_taken=0, giving a latency of one cycle from dout/npc_in to IR/npc_out/controls.
REQ-018 When enable_decode=0 and br_taken=0, the module SHALL hold every output unchanged (stall).
REQ-019 When br_taken=1, the module SHALL clear valid_out, reg_wr, Mem_Control and illegal_op on the next edge while holding IR and npc_out, regardless of enable_decode (flush wins over capture).
REQ-020 On capture, the module SHALL set valid_out=1 and increment decode_count by 1 modulo 2^16 (0xFFFF wraps to 0x0000); flush and stall cycles SHALL NOT increment it.
REQ-021 The opcode SHALL be dout[15:12].
REQ-022 Control for ADD (0001) SHALL be: E_Control = 00_00_0_op2select, W_Control=00, reg_wr=1, with op2select = ~dout[5].
REQ-023 Control for AND (0101) SHALL be: E_Control = 01_00_0_op2select, W_Control=00, reg_wr=1, with op2select = ~dout[5].
REQ-024 Control for NOT (1001) SHALL be: E_Control=10_00_0_0, W_Control=00, reg_wr=1.
REQ-025 Control for BR (0000) SHALL be: E_Control=00_01_1_0, reg_wr=0.
REQ-026 Control for JMP (1100) SHALL be: E_Control=00_11_0_0, reg_wr=0.
REQ-027 Control for LD (0010) and LDI (1010) SHALL be: E_Control=00_01_1_0, W_Control=01, reg_wr=1.
REQ-028 Control for LDR (0110) SHALL be: E_Control=00_10_0_0, W_Control=01, reg_wr=1.
REQ-029 Control for ST (0011) and STI (1011) SHALL be: E_Control=00_01_1_0, W_Control=00, reg_wr=0.
REQ-030 Control for STR (0111) SHALL be: E_Control=00_10_0_0, W_Control=00, reg_wr=0.
REQ-031 Control for LEA (1110) SHALL be: E_Control=00_01_1_0, W_Control=10, reg_wr=1.
REQ-032 Mem_Control SHALL be 1 only for LDI and STI.
REQ-033 For opcodes 0100, 1000, 1101 and 1111, the module SHALL set illegal_op=1, E_Control=0, W_Control=0, reg_wr=0 and Mem_Control=0, with valid_out=1 and decode_count incremented.

Reset
REQ-034 When reset=1 at a rising edge, the module SHALL set IR=0x0000, npc_out=0x0000, E_Control=0, W_Control=0, Mem_Control=0, reg_wr=0, valid_out=0, illegal_op=0 and decode_count=0.
REQ-035 Reset SHALL override enable_decode and br_taken, and SHALL take effect even mid-stall or mid-flush.
REQ-036 The first capture after reset deassertion SHALL make decode_count=1.

Verification
REQ-037 Bench case ADD register form: dout=0x1042, npc_in=0x3001, enable_decode=1 -> next cycle IR=0x1042, npc_out=0x3001, E_Control=000001, W_Control=00, reg_wr=1, valid_out=1.
REQ-038 Bench case LDI then STR back-to-back: dout=0xA403 then 0x7A82 -> first cycle Mem_Control=1, W_Control=01; second cycle Mem_Control=0, E_Control=001000, reg_wr=0.
REQ-039 Bench case stall: enable_decode=0 for 3 cycles while dout changes -> all outputs and decode_count are frozen.
REQ-040 Bench case flush: br_taken=1 together with enable_decode=1 and dout=0x5020 -> valid_out=0, reg_wr=0, IR unchanged, decode_count unchanged.
REQ-041 Bench case illegal opcode: dout=0xD000 -> illegal_op=1, E_Control=0, reg_wr=0, valid_out=1.
REQ-042 Bench case counter wrap and reset: force 65536 captures -> decode_count=0x0000; assert reset mid-stream -> every output reads its REQ-034 reset value on the next edge.
